// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO port scheduler.
//   def_width  : data word width, matches the FIFO width
//   def_depth  : FIFO depth in words
//   def_cnt_w  : width of the FIFO occupancy count
//   def_n_req  : default number of write requesters
//   def_idx_w  : width of a requester index
package fifo_pkg;

    localparam int def_width = 16;
    localparam int def_depth = 16;
    localparam int def_cnt_w = 6;
    localparam int def_n_req = 4;
    localparam int def_idx_w = $clog2(def_n_req);

endpackage

// File: rtl/fifo_port_sched_rr_arbiter.sv
// Round-robin arbiter for the FIFO write side.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector, one bit per requester
//   accept_en  : high when a grant may be accepted (FIFO not full, out of reset)
//   grant      : one-hot grant, zero when nothing is accepted
//   any_req    : at least one requester is valid
//   ptr        : index of the last accepted requester (registered)
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter  int n_req = def_n_req,
    localparam int idx_w = $clog2(n_req)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [n_req-1:0] req,
    input  logic             accept_en,
    output logic [n_req-1:0] grant,
    output logic             any_req,
    output logic [idx_w-1:0] ptr
);

    logic [idx_w-1:0] win_idx;
    logic [idx_w-1:0] cand;
    logic [idx_w:0]   sum;

    // Search starts one past the last winner and wraps; the first hit wins.
    always_comb begin
        win_idx = '0;
        any_req = 1'b0;
        cand    = '0;
        sum     = '0;
        for (int k = 1; k <= n_req; k++) begin
            sum = {1'b0, ptr} + (idx_w+1)'(k);
            if (sum >= (idx_w+1)'(n_req))
                sum = sum - (idx_w+1)'(n_req);
            cand = sum[idx_w-1:0];
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (any_req && accept_en)
            grant[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= idx_w'(n_req - 1);
        else if (any_req && accept_en)
            ptr <= win_idx;
    end

endmodule

// File: rtl/fifo_port_sched.sv
// Shares one FIFO between n_req producers and drains it to a single consumer.
//   clk, reset          : clock, async active-low reset
//   req_valid/req_data  : per-requester write requests, word i at [i*width +: width]
//   req_ready           : one-hot acceptance this cycle
//   grant_id            : last accepted requester (registered)
//   fifo_w_en/fifo_din  : FIFO write port
//   fifo_full           : FIFO full flag
//   fifo_r_en/fifo_dout : FIFO read port, data valid one cycle after fifo_r_en
//   fifo_empty          : FIFO empty flag
//   fifo_count          : FIFO occupancy, mirrored to level
//   out_valid/out_data/out_ready : consumer handshake
//   level               : registered copy of fifo_count
module fifo_port_sched
    import fifo_pkg::*;
#(
    parameter  int width = def_width,
    parameter  int n_req = def_n_req,
    parameter  int cnt_w = def_cnt_w,
    localparam int idx_w = $clog2(n_req)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [n_req-1:0]       req_valid,
    input  logic [n_req*width-1:0] req_data,
    output logic [n_req-1:0]       req_ready,
    output logic [idx_w-1:0]       grant_id,
    output logic                   fifo_w_en,
    output logic [width-1:0]       fifo_din,
    input  logic                   fifo_full,
    output logic                   fifo_r_en,
    input  logic [width-1:0]       fifo_dout,
    input  logic                   fifo_empty,
    input  logic [cnt_w-1:0]       fifo_count,
    output logic                   out_valid,
    output logic [width-1:0]       out_data,
    input  logic                   out_ready,
    output logic [cnt_w-1:0]       level
);

    logic             accept_en;
    logic             any_req;
    logic [n_req-1:0] grant;

    // Combinational outputs are forced low while reset is held.
    assign accept_en = reset & ~fifo_full;

    rr_arbiter #(.n_req(n_req)) u_arb (
        .clk       (clk),
        .rst_n     (reset),
        .req       (req_valid),
        .accept_en (accept_en),
        .grant     (grant),
        .any_req   (any_req),
        .ptr       (grant_id)
    );

    assign req_ready = grant;
    assign fifo_w_en = any_req & accept_en;

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < n_req; i++)
            if (grant[i])
                fifo_din = fifo_din | req_data[i*width +: width];
    end

    // Two-entry skid buffer absorbing the FIFO's one-cycle read latency.
    logic [width-1:0] skid [2];
    logic             hd;
    logic             tl;
    logic [1:0]       occ;
    logic             inflight;
    logic             pop;
    logic             push;
    logic [1:0]       held;

    assign out_valid = (occ != 2'd0);
    assign out_data  = skid[hd];
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // Slots still committed after this cycle's pop; a read is only issued
    // when one slot remains free for the returning word.
    assign held      = occ - {1'b0, pop} + {1'b0, inflight};
    assign fifo_r_en = reset & ~fifo_empty & (held < 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid[0]  <= '0;
            skid[1]  <= '0;
            hd       <= 1'b0;
            tl       <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            level    <= '0;
        end else begin
            inflight <= fifo_r_en;
            level    <= fifo_count;
            if (push) begin
                skid[tl] <= fifo_dout;
                tl       <= ~tl;
            end
            if (pop)
                hd <= ~hd;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_port_sched.sv
module tb_fifo_port_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        fifo_w_en;
    logic [15:0] fifo_din;
    logic        fifo_full;
    logic        fifo_r_en;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic [5:0]  fifo_count;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [5:0]  level;

    fifo_port_sched dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant_id   (grant_id),
        .fifo_w_en  (fifo_w_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .fifo_r_en  (fifo_r_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16-deep FIFO with registered flags and one-cycle read data.
    logic [15:0] mem [16];
    logic [3:0]  wp;
    logic [3:0]  rp;
    logic [4:0]  cnt;
    logic        wr_ok;
    logic        rd_ok;

    assign wr_ok      = fifo_w_en && (cnt != 5'd16);
    assign rd_ok      = fifo_r_en && (cnt != 5'd0);
    assign fifo_full  = (cnt == 5'd16);
    assign fifo_empty = (cnt == 5'd0);
    assign fifo_count = {1'b0, cnt};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 5'd0;
            wp        <= 4'd0;
            rp        <= 4'd0;
            fifo_dout <= 16'd0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= fifo_din;
                wp      <= wp + 4'd1;
            end
            if (rd_ok) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 4'd1;
            end
            cnt <= cnt + 5'(wr_ok) - 5'(rd_ok);
        end
    end

    int          n_chk;
    int          n_pass;
    int          sent [4];
    int          lim [4];
    logic        fixed_mode;
    int          rdy_mode;
    logic        rdy_phase;
    logic [15:0] base;
    logic [15:0] got_q [$];
    int          wr_q [$];
    int          rd_cnt;
    int          pop_cnt;
    int          viol;
    int          tick_no;
    int          first_pop;
    int          level_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (sent[i] < lim[i]);
            req_data[i*16 +: 16] = fixed_mode ? (16'hA000 + 16'(i)) : (base + 16'(sent[i]));
        end
        out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? rdy_phase : 1'b0;
    endtask

    // Sample just after the previous negedge (well before the posedge),
    // then wait through the edge and drive the next cycle's inputs.
    task automatic tick();
        logic pop;
        #1;
        pop = out_valid && out_ready;
        if (fifo_r_en && ((rd_cnt - pop_cnt - int'(pop)) >= 2))
            viol++;
        if (pop) begin
            got_q.push_back(out_data);
            pop_cnt++;
            if (first_pop < 0)
                first_pop = tick_no;
        end
        if (fifo_r_en)
            rd_cnt++;
        for (int i = 0; i < 4; i++)
            if (req_ready[i]) begin
                wr_q.push_back(i);
                sent[i]++;
            end
        @(negedge clk);
        rdy_phase = ~rdy_phase;
        drive_inputs();
        tick_no++;
    endtask

    task automatic clear_hist();
        got_q.delete();
        wr_q.delete();
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            lim[i]  = 0;
        end
    endtask

    function automatic int order_errs(input logic [15:0] b, input int n);
        int e;
        e = 0;
        for (int k = 0; k < n; k++)
            if (k >= got_q.size() || got_q[k] !== b + 16'(k))
                e++;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0;
        rd_cnt = 0; pop_cnt = 0; viol = 0;
        tick_no = 0; first_pop = -1;
        rdy_mode = 1; rdy_phase = 1'b1; base = 16'h0;
        clear_hist();
        fixed_mode = 1'b1;
        for (int i = 0; i < 4; i++) lim[i] = 1000;
        reset = 1'b0;
        drive_inputs();

        // Reset with all requesters valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_w_en",      32'(fifo_w_en), 32'h0);
        chk("rst_r_en",      32'(fifo_r_en), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_level",     32'(level),     32'h0);
        chk("rst_grant_id",  32'(grant_id),  32'h3);
        chk("rst_din",       32'(fifo_din),  32'h0);

        // Fairness, sustained throughput
        @(negedge clk);
        reset = 1'b1;
        drive_inputs();
        tick_no = 0;
        repeat (12) tick();
        for (int k = 0; k < 8; k++)
            chk("rr_order", 32'(wr_q[k]), 32'(k % 4));
        chk("fair_first_pop", 32'(first_pop), 32'd3);
        chk("fair_pop_count", 32'(got_q.size()), 32'd9);
        level_bad = 0;
        for (int k = 0; k < got_q.size(); k++)
            if (got_q[k] !== 16'hA000 + 16'(k % 4)) level_bad++;
        chk("fair_data", 32'(level_bad), 32'd0);
        chk("fair_level", 32'(level), 32'd1);
        chk("fair_grant_id", 32'(grant_id), 32'd3);
        for (int i = 0; i < 4; i++) lim[i] = 0;
        drive_inputs();
        repeat (20) tick();
        chk("fair_drain_count", 32'(got_q.size()), 32'd12);

        // Full FIFO with consumer stalled
        clear_hist();
        fixed_mode = 1'b0;
        base = 16'h0;
        lim[2] = 32;
        rdy_mode = 0;
        drive_inputs();
        repeat (40) tick();
        #1;
        chk("full_accepted", 32'(sent[2]), 32'd18);
        chk("full_flag", 32'(fifo_full), 32'd1);
        chk("full_req_ready", 32'(req_ready), 32'h0);
        chk("full_w_en", 32'(fifo_w_en), 32'h0);
        chk("full_grant_id", 32'(grant_id), 32'd2);
        chk("full_level", 32'(level), 32'd16);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_out_data", 32'(out_data), 32'h0);
        chk("full_r_en", 32'(fifo_r_en), 32'h0);
        rdy_mode = 1;
        drive_inputs();
        repeat (60) tick();
        chk("full_count", 32'(got_q.size()), 32'd32);
        chk("full_order", 32'(order_errs(16'h0, 32)), 32'd0);

        // Back-pressure toggling
        clear_hist();
        viol = 0;
        lim[1] = 32;
        rdy_mode = 2;
        drive_inputs();
        repeat (120) tick();
        chk("bp_count", 32'(got_q.size()), 32'd32);
        chk("bp_order", 32'(order_errs(16'h0, 32)), 32'd0);
        chk("bp_no_overissue", 32'(viol), 32'd0);

        // Simultaneous read and write at level 5
        clear_hist();
        base = 16'h5000;
        lim[3] = 7;
        rdy_mode = 0;
        drive_inputs();
        repeat (15) tick();
        chk("rw_level_pre", 32'(level), 32'd5);
        lim[3] = 27;
        rdy_mode = 1;
        drive_inputs();
        level_bad = 0;
        repeat (10) begin
            tick();
            if (level != 6'd5) level_bad++;
        end
        chk("rw_level_hold", 32'(level_bad), 32'd0);
        repeat (40) tick();
        chk("rw_count", 32'(got_q.size()), 32'd27);
        chk("rw_order", 32'(order_errs(16'h5000, 27)), 32'd0);

        // Mid-operation reset with the skid full
        clear_hist();
        base = 16'h0200;
        lim[0] = 10;
        rdy_mode = 0;
        drive_inputs();
        repeat (8) tick();
        #1;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_data", 32'(out_data), 32'h0);
        chk("mid_grant_id", 32'(grant_id), 32'd3);
        chk("mid_r_en", 32'(fifo_r_en), 32'd0);
        clear_hist();
        rd_cnt = 0; pop_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        base = 16'h0300;
        lim[0] = 5;
        rdy_mode = 1;
        drive_inputs();
        repeat (20) tick();
        chk("mid_count", 32'(got_q.size()), 32'd5);
        chk("mid_order", 32'(order_errs(16'h0300, 5)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
